// File: rtl/core_memsys_pkg.sv
// Shared definitions for the core memory subsystem: address map, CLINT
// register offsets, arbiter state and the request record held in pending slots.
package core_memsys_pkg;

    localparam logic [31:0] DEF_BRAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DEF_BRAM_TOP   = 32'h0001_0000;
    localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_SIZE     = 32'h0000_C000;
    localparam logic [31:0] DEF_CLINT_TOP  = DEF_CLINT_BASE + CLINT_SIZE;

    localparam logic [31:0] CLINT_MSIP        = 32'h0000_0000;
    localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
    localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
    localparam logic [31:0] CLINT_MTIME_LO    = 32'h0000_BFF8;
    localparam logic [31:0] CLINT_MTIME_HI    = 32'h0000_BFFC;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_NEXT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        TGT_NONE  = 2'd0,
        TGT_BRAM  = 2'd1,
        TGT_CLINT = 2'd2
    } tgt_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    function automatic logic [31:0] strobe_merge(input logic [31:0] old_val,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  wstrb);
        logic [31:0] r;
        r = old_val;
        for (int k = 0; k < 4; k++) begin
            if (wstrb[k]) r[8*k +: 8] = wdata[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/core_memsys_if.sv
// One request/response port of the memory subsystem; used for both CPU ports
// and for the internal bus between the arbiter and the targets.
interface core_memsys_if;
    // valid is a single-cycle pulse qualifying instr/addr/wdata/wstrb (wstrb==0
    // is a read); the responder answers with a single-cycle ready pulse that
    // qualifies rdata. A requester keeps at most one request outstanding.
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (output valid, instr, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/core_memsys_arbiter.sv
// Two-requester arbiter: data port has priority, the losing or late request is
// parked in a per-port pending slot and issued the cycle after the bus answers.
module core_memsys_arbiter
    import core_memsys_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    core_memsys_if.slave  imemory,
    core_memsys_if.slave  dmemory,
    core_memsys_if.master bus,
    output arb_state_t    state
);

    arb_state_t state_q, state_d;
    logic       owner_d_q, owner_d_d;
    logic       i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    req_t       i_slot_q, i_slot_d, d_slot_q, d_slot_d;
    req_t       i_live, d_live, issue_req;
    logic       issue_valid;

    assign i_live = '{instr: imemory.instr, addr: imemory.addr,
                      wdata: imemory.wdata, wstrb: imemory.wstrb};
    assign d_live = '{instr: dmemory.instr, addr: dmemory.addr,
                      wdata: dmemory.wdata, wstrb: dmemory.wstrb};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            owner_d_q <= 1'b0;
            i_pend_q  <= 1'b0;
            d_pend_q  <= 1'b0;
            i_slot_q  <= '0;
            d_slot_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_d_q <= owner_d_d;
            i_pend_q  <= i_pend_d;
            d_pend_q  <= d_pend_d;
            i_slot_q  <= i_slot_d;
            d_slot_q  <= d_slot_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        i_pend_d    = i_pend_q;
        d_pend_d    = d_pend_q;
        i_slot_d    = i_slot_q;
        d_slot_d    = d_slot_q;
        issue_valid = 1'b0;
        issue_req   = '0;
        case (state_q)
            ARB_BUSY: begin
                if (bus.ready) state_d = ARB_NEXT;
                if (imemory.valid) begin
                    i_pend_d = 1'b1;
                    i_slot_d = i_live;
                end
                if (dmemory.valid) begin
                    d_pend_d = 1'b1;
                    d_slot_d = d_live;
                end
            end
            default: begin
                // IDLE and the cycle after a response share one issue path;
                // pending slots are only ever non-empty in the latter.
                state_d = ARB_IDLE;
                if (d_pend_q || dmemory.valid) begin
                    issue_valid = 1'b1;
                    issue_req   = d_pend_q ? d_slot_q : d_live;
                    d_pend_d    = 1'b0;
                    owner_d_d   = 1'b1;
                    state_d     = ARB_BUSY;
                    if (imemory.valid) begin
                        i_pend_d = 1'b1;
                        i_slot_d = i_live;
                    end
                end else if (i_pend_q || imemory.valid) begin
                    issue_valid = 1'b1;
                    issue_req   = i_pend_q ? i_slot_q : i_live;
                    i_pend_d    = 1'b0;
                    owner_d_d   = 1'b0;
                    state_d     = ARB_BUSY;
                end
            end
        endcase
    end

    assign bus.valid = issue_valid;
    assign bus.instr = issue_req.instr;
    assign bus.addr  = issue_req.addr;
    assign bus.wdata = issue_req.wdata;
    assign bus.wstrb = issue_req.wstrb;

    assign dmemory.ready = bus.ready && (state_q == ARB_BUSY) && owner_d_q;
    assign imemory.ready = bus.ready && (state_q == ARB_BUSY) && !owner_d_q;
    assign dmemory.rdata = dmemory.ready ? bus.rdata : 32'd0;
    assign imemory.rdata = imemory.ready ? bus.rdata : 32'd0;

    assign state = state_q;

endmodule

// File: rtl/core_memsys.sv
// Memory subsystem top: arbitrated CPU ports decoded onto a word-addressed
// block RAM and a RISC-V CLINT; every target answers one cycle after issue.
module core_memsys
    import core_memsys_pkg::*;
#(
    parameter int          BRAM_DEPTH = 16384,
    parameter logic [31:0] BRAM_BASE  = DEF_BRAM_BASE,
    parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
    parameter string       INIT_FILE  = "bram.dat"
) (
    input  logic         clock,
    input  logic         reset,
    core_memsys_if.slave imemory,
    core_memsys_if.slave dmemory,
    output logic         msip,
    output logic         mtip,
    output logic [63:0]  mtime,
    output arb_state_t   arb_state
);

    localparam int          IDX_W      = $clog2(BRAM_DEPTH);
    localparam logic [32:0] BRAM_SPAN  = 33'(BRAM_DEPTH) * 33'd4;
    localparam logic [32:0] CLINT_SPAN = {1'b0, CLINT_SIZE};

    core_memsys_if bus ();

    core_memsys_arbiter u_arbiter (
        .clock   (clock),
        .reset   (reset),
        .imemory (imemory),
        .dmemory (dmemory),
        .bus     (bus),
        .state   (arb_state)
    );

    // 33-bit differences: an address below a base wraps to a huge value, so
    // one unsigned compare checks both ends of each window.
    logic [32:0] bram_diff, clint_diff;
    logic [31:0] clint_off;
    logic        sel_bram, sel_clint, is_write;
    logic        unused_instr;

    assign bram_diff    = {1'b0, bus.addr} - {1'b0, BRAM_BASE};
    assign clint_diff   = {1'b0, bus.addr} - {1'b0, CLINT_BASE};
    assign sel_bram     = bram_diff < BRAM_SPAN;
    assign sel_clint    = clint_diff < CLINT_SPAN;
    assign clint_off    = clint_diff[31:0];
    assign is_write     = |bus.wstrb;
    assign unused_instr = bus.instr;

    logic [31:0]      bram [BRAM_DEPTH];
    logic [31:0]      bram_rdata;
    logic [IDX_W-1:0] bram_idx;

    assign bram_idx = bram_diff[IDX_W+1:2];

    always_ff @(posedge clock) begin
        if (bus.valid && sel_bram) begin
            if (bus.wstrb[0]) bram[bram_idx][7:0]   <= bus.wdata[7:0];
            if (bus.wstrb[1]) bram[bram_idx][15:8]  <= bus.wdata[15:8];
            if (bus.wstrb[2]) bram[bram_idx][23:16] <= bus.wdata[23:16];
            if (bus.wstrb[3]) bram[bram_idx][31:24] <= bus.wdata[31:24];
            bram_rdata <= bram[bram_idx];
        end
    end

    logic        msip_q, mtip_q, clint_we;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [31:0] clint_rd_val, clint_rdata;

    assign clint_we = bus.valid && sel_clint && is_write;

    // A written mtime half overrides the increment; the other half keeps the
    // incremented (pre-write) value so the carry still propagates.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (clint_we) begin
            case (clint_off)
                CLINT_MTIME_LO:    mtime_d[31:0]     = strobe_merge(mtime_q[31:0], bus.wdata, bus.wstrb);
                CLINT_MTIME_HI:    mtime_d[63:32]    = strobe_merge(mtime_q[63:32], bus.wdata, bus.wstrb);
                CLINT_MTIMECMP_LO: mtimecmp_d[31:0]  = strobe_merge(mtimecmp_q[31:0], bus.wdata, bus.wstrb);
                CLINT_MTIMECMP_HI: mtimecmp_d[63:32] = strobe_merge(mtimecmp_q[63:32], bus.wdata, bus.wstrb);
                default: ;
            endcase
        end
    end

    always_comb begin
        clint_rd_val = '0;
        case (clint_off)
            CLINT_MSIP:        clint_rd_val = {31'd0, msip_q};
            CLINT_MTIMECMP_LO: clint_rd_val = mtimecmp_q[31:0];
            CLINT_MTIMECMP_HI: clint_rd_val = mtimecmp_q[63:32];
            CLINT_MTIME_LO:    clint_rd_val = mtime_q[31:0];
            CLINT_MTIME_HI:    clint_rd_val = mtime_q[63:32];
            default:           clint_rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            clint_rdata <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= (mtime_q >= mtimecmp_q);
            if (clint_we && (clint_off == CLINT_MSIP) && bus.wstrb[0]) msip_q <= bus.wdata[0];
            if (bus.valid && sel_clint) clint_rdata <= clint_rd_val;
        end
    end

    logic        resp_valid, resp_write;
    tgt_t        resp_tgt;
    logic [31:0] resp_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_tgt   <= TGT_NONE;
        end else begin
            resp_valid <= bus.valid;
            resp_write <= is_write;
            resp_tgt   <= sel_bram ? TGT_BRAM : (sel_clint ? TGT_CLINT : TGT_NONE);
        end
    end

    always_comb begin
        resp_rdata = '0;
        if (resp_valid && !resp_write) begin
            case (resp_tgt)
                TGT_BRAM:  resp_rdata = bram_rdata;
                TGT_CLINT: resp_rdata = clint_rdata;
                default:   resp_rdata = '0;
            endcase
        end
    end

    assign bus.ready = resp_valid;
    assign bus.rdata = resp_rdata;

    assign msip  = msip_q;
    assign mtip  = mtip_q;
    assign mtime = mtime_q;

endmodule

// File: tb/tb_core_memsys.sv
// Directed bench for core_memsys: per-port expected-rdata queues checked on
// every ready pulse, plus cycle-exact ready, interrupt and timer checks.
module tb_core_memsys;
    import core_memsys_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        msip, mtip;
    logic [63:0] mtime;
    arb_state_t  arb_state;

    core_memsys_if imemory ();
    core_memsys_if dmemory ();

    core_memsys #(.INIT_FILE("")) dut (
        .clock     (clock),
        .reset     (reset),
        .imemory   (imemory),
        .dmemory   (dmemory),
        .msip      (msip),
        .mtip      (mtip),
        .mtime     (mtime),
        .arb_state (arb_state)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ports();
        imemory.valid = 1'b0; imemory.instr = 1'b0; imemory.addr = '0; imemory.wdata = '0; imemory.wstrb = '0;
        dmemory.valid = 1'b0; dmemory.instr = 1'b0; dmemory.addr = '0; dmemory.wdata = '0; dmemory.wstrb = '0;
    endtask

    task automatic drive(input bit to_d, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rdata);
        if (to_d) begin
            dmemory.valid = 1'b1; dmemory.instr = 1'b0; dmemory.addr = addr;
            dmemory.wdata = wdata; dmemory.wstrb = wstrb;
            d_exp_q.push_back(exp_rdata);
        end else begin
            imemory.valid = 1'b1; imemory.instr = 1'b1; imemory.addr = addr;
            imemory.wdata = wdata; imemory.wstrb = wstrb;
            i_exp_q.push_back(exp_rdata);
        end
    endtask

    // Single request on an otherwise quiet subsystem: ready exactly one cycle later.
    task automatic txn(input bit to_d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp_rdata, input string tag);
        drive(to_d, addr, wdata, wstrb, exp_rdata);
        step();
        idle_ports();
        check({tag, "_ready"}, 64'(to_d ? dmemory.ready : imemory.ready), 64'd1);
        check({tag, "_other"}, 64'(to_d ? imemory.ready : dmemory.ready), 64'd0);
        step();
        check({tag, "_pulse"}, 64'(to_d ? dmemory.ready : imemory.ready), 64'd0);
    endtask

    always @(negedge clock) begin
        if (dmemory.ready) begin
            if (d_exp_q.size() == 0) check("d_spurious_ready", 64'd1, 64'd0);
            else check("d_rdata", 64'(dmemory.rdata), 64'(d_exp_q.pop_front()));
        end
        if (imemory.ready) begin
            if (i_exp_q.size() == 0) check("i_spurious_ready", 64'd1, 64'd0);
            else check("i_rdata", 64'(imemory.rdata), 64'(i_exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_ports();
        repeat (3) step();
        check("rst_dready", 64'(dmemory.ready), 64'd0);
        check("rst_iready", 64'(imemory.ready), 64'd0);
        check("rst_drdata", 64'(dmemory.rdata), 64'd0);
        check("rst_msip", 64'(msip), 64'd0);
        check("rst_mtip", 64'(mtip), 64'd0);
        check("rst_mtime", mtime, 64'd0);
        check("rst_state", 64'(arb_state), 64'(ARB_IDLE));

        reset = 1'b1;
        repeat (3) step();
        check("mtime_count", mtime, 64'd3);

        // RAM word write, read, then a lane-1 byte write (0xBE -> 0xAA).
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr_10");
        txn(1'b1, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, "rd_10");
        txn(1'b1, 32'h10, 32'h0000_AA00, 4'h2, 32'h0, "wrb_10");
        txn(1'b1, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, "rdb_10");
        txn(1'b1, 32'h100, 32'h0000_0013, 4'hF, 32'h0, "wr_100");
        txn(1'b1, 32'h104, 32'h1234_5678, 4'hF, 32'h0, "wr_104");

        // Both ports in the same cycle: data first, instruction two cycles later.
        drive(1'b0, 32'h100, 32'h0, 4'h0, 32'h0000_0013);
        drive(1'b1, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF);
        step(); idle_ports();
        check("both_c1_d", 64'(dmemory.ready), 64'd1);
        check("both_c1_i", 64'(imemory.ready), 64'd0);
        step();
        check("both_c2_d", 64'(dmemory.ready), 64'd0);
        check("both_c2_i", 64'(imemory.ready), 64'd0);
        step();
        check("both_c3_i", 64'(imemory.ready), 64'd1);
        check("both_c3_d", 64'(dmemory.ready), 64'd0);
        step();
        check("both_c4_i", 64'(imemory.ready), 64'd0);

        // Instruction request arriving while the data request is in flight.
        drive(1'b1, 32'h104, 32'h0, 4'h0, 32'h1234_5678);
        step(); idle_ports();
        drive(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF);
        check("busy_c1_d", 64'(dmemory.ready), 64'd1);
        check("busy_c1_i", 64'(imemory.ready), 64'd0);
        step(); idle_ports();
        check("busy_c2_i", 64'(imemory.ready), 64'd0);
        step();
        check("busy_c3_i", 64'(imemory.ready), 64'd1);
        check("busy_c3_d", 64'(dmemory.ready), 64'd0);
        step();
        check("busy_c4_i", 64'(imemory.ready), 64'd0);

        // Instruction-port write, data-port readback; RAM edges and aliasing.
        txn(1'b0, 32'h200, 32'hCAFE_F00D, 4'hF, 32'h0, "iwr_200");
        txn(1'b1, 32'h200, 32'h0, 4'h0, 32'hCAFE_F00D, "rd_200");
        txn(1'b1, 32'h0, 32'h0000_0055, 4'hF, 32'h0, "wr_0");
        txn(1'b1, 32'hFFFC, 32'hA5A5_0001, 4'hF, 32'h0, "wr_top");
        txn(1'b1, 32'h1_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_past_top");
        txn(1'b1, 32'h0, 32'h0, 4'h0, 32'h0000_0055, "rd_0");
        txn(1'b1, 32'hFFFC, 32'h0, 4'h0, 32'hA5A5_0001, "rd_top");
        txn(1'b1, 32'h1_0000, 32'h0, 4'h0, 32'h0, "rd_past_top");
        txn(1'b0, 32'h1000_0000, 32'h0, 4'h0, 32'h0, "i_unmapped");
        txn(1'b1, 32'h1000_0000, 32'h0, 4'h0, 32'h0, "d_unmapped");

        // Timer compare.
        txn(1'b1, 32'h0200_4000, 32'h20, 4'hF, 32'h0, "wr_cmp_lo");
        txn(1'b1, 32'h0200_4000, 32'h0, 4'h0, 32'h20, "rd_cmp_lo");
        txn(1'b1, 32'h0200_4004, 32'h0, 4'h0, 32'hFFFF_FFFF, "rd_cmp_hi");
        txn(1'b1, 32'h0200_BFF8, 32'h0, 4'hF, 32'h0, "wr_mtime_lo");
        txn(1'b1, 32'h0200_4004, 32'h0, 4'hF, 32'h0, "wr_cmp_hi");
        check("mtip_low", 64'(mtip), 64'd0);
        for (int c = 0; c < 200; c++) begin
            if (mtime == 64'h20) break;
            step();
        end
        check("mtime_reach_20", mtime, 64'h20);
        check("mtip_at_eq", 64'(mtip), 64'd0);
        step();
        check("mtip_rise", 64'(mtip), 64'd1);
        txn(1'b1, 32'h0200_4004, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_cmp_hi_max");
        check("mtip_fall", 64'(mtip), 64'd0);

        // Written low half wins over the increment; the carry lands next cycle.
        drive(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, 32'h0);
        step(); idle_ports();
        check("mtime_wr_lo", mtime, 64'h0000_0000_FFFF_FFFF);
        step();
        check("mtime_carry", mtime, 64'h0000_0001_0000_0000);
        txn(1'b1, 32'h0200_BFFC, 32'h0, 4'h0, 32'h1, "rd_mtime_hi");

        // Software interrupt and reserved CLINT offsets.
        txn(1'b1, 32'h0200_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_msip");
        check("msip_set", 64'(msip), 64'd1);
        txn(1'b1, 32'h0200_0000, 32'h0, 4'h0, 32'h1, "rd_msip");
        txn(1'b1, 32'h0200_0000, 32'h0, 4'hF, 32'h0, "clr_msip");
        check("msip_clr", 64'(msip), 64'd0);
        txn(1'b1, 32'h0200_0004, 32'h1234_5678, 4'hF, 32'h0, "wr_rsvd");
        txn(1'b1, 32'h0200_0004, 32'h0, 4'h0, 32'h0, "rd_rsvd");

        // Reset in the middle of a transaction: no response, RAM keeps data.
        dmemory.valid = 1'b1; dmemory.addr = 32'h10; dmemory.wstrb = 4'h0;
        #2 reset = 1'b0;
        idle_ports();
        step();
        check("abort_ready", 64'(dmemory.ready), 64'd0);
        check("abort_mtime", mtime, 64'd0);
        reset = 1'b1;
        step();
        check("abort_ready2", 64'(dmemory.ready), 64'd0);
        check("abort_state", 64'(arb_state), 64'(ARB_IDLE));
        txn(1'b1, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, "rd_after_rst");

        step();
        check("d_queue_empty", 64'(d_exp_q.size()), 64'd0);
        check("i_queue_empty", 64'(i_exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
